// File: rtl/ps2_command_tx.sv
// ---------------------------------------------------------------------------
// ps2_command_tx
//
// Host-to-device PS/2 command transmitter. It accepts one command byte at a
// time and sends it to a PS/2 device (keyboard/mouse):
//   1. Inhibit: hold PS2_CLK low for INHIBIT_CYCLES clocks.
//   2. Request-to-send: release PS2_CLK and drive PS2_DAT low (start bit).
//   3. The device generates the bit clock. The host changes PS2_DAT on each
//      falling edge: data LSB first, then odd parity, then the stop bit
//      (line released).
//   4. The device drives its ACK bit, which is sampled on the next falling
//      edge.
//   5. The transfer completes once both lines are back high (bus idle).
//
// Both PS/2 lines are open-collector. The *_oe outputs pull a line low when
// they are 1 and release it when they are 0. The raw pin levels come back in
// on ps2_clk_in and ps2_dat_in.
//
// Handshake: a byte is taken on any rising clock edge where
// tx_valid && tx_ready. tx_valid may stay high while tx_ready is low; the
// request is not taken until tx_ready returns. tx_data is captured only on
// the accepting edge.
//
// Optional feature (compile-time macro PS2_TX_TIMEOUT_EN):
//   When the macro is defined, a watchdog starts counting when INHIBIT ends.
//   If it reaches TIMEOUT_CYCLES before WAIT_IDLE completes, the transfer is
//   aborted: both lines are released, tx_timeout pulses, and the block
//   returns to IDLE without tx_done.
//   When the macro is undefined, there is no watchdog and tx_timeout is
//   tied to 0. A device that stalls then keeps the block busy until reset.
//
// Parameters:
//   INHIBIT_CYCLES  clock-inhibit length in clocks (use 3 or more, so the
//                   synchronised falling edge caused by the inhibit itself
//                   is seen while still in INHIBIT and ignored there)
//   TIMEOUT_CYCLES  watchdog limit in clocks (used only with the macro)
//
// Ports:
//   clock        system clock; all logic runs on its rising edge
//   reset        synchronous, active-high reset
//   tx_valid     request to send tx_data
//   tx_data      command byte
//   tx_ready     high only in IDLE, and not in the tx_done cycle
//   busy         high in every state except IDLE
//   tx_done      one-cycle pulse at transfer end
//   tx_ack_err   one-cycle pulse with tx_done when the ACK bit sampled high
//   tx_timeout   one-cycle pulse on watchdog abort
//   ps2_clk_in   raw PS2_CLK level (asynchronous)
//   ps2_dat_in   raw PS2_DAT level (asynchronous)
//   ps2_clk_oe   1 = pull PS2_CLK low
//   ps2_dat_oe   1 = pull PS2_DAT low
//   state_dbg    current FSM state encoding (debug observation)
// ---------------------------------------------------------------------------
module ps2_command_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_ack_err,
    output logic       tx_timeout,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic [2:0] state_dbg
);

    // State encoding. START..WAIT_IDLE are numbered consecutively, so the
    // watchdog window can be tested as "not IDLE and not INHIBIT".
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_DATA      = 3'd3;
    localparam logic [2:0] S_PARITY    = 3'd4;
    localparam logic [2:0] S_STOP      = 3'd5;
    localparam logic [2:0] S_ACK       = 3'd6;
    localparam logic [2:0] S_WAIT_IDLE = 3'd7;

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

    logic [2:0]       state;

    // Pin synchronisers. Reset values are "idle high", so leaving reset
    // cannot look like a falling edge.
    logic             clk_s1, clk_s2, clk_prev;
    logic             dat_s1, dat_s2;
    logic             clk_fall;

    // Transfer datapath
    logic [7:0]       shreg;      // bit presented next sits at shreg[1]
    logic             parity_q;   // odd parity of the accepted byte
    logic [2:0]       bit_idx;    // data bit currently on the wire
    logic [INH_W-1:0] inh_cnt;
    logic             ack_q;      // ACK level sampled from the device

    logic             clk_oe_q, dat_oe_q;
    logic             done_q, ack_err_q;
    logic             accept;
    logic             bus_idle;

    // -----------------------------------------------------------------------
    // Synchronisers and falling-edge detect
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_dat_in;
            dat_s2   <= dat_s1;
        end
    end

    assign clk_fall = clk_prev & ~clk_s2;
    assign bus_idle = clk_s2 & dat_s2;

    // tx_ready is held low in the tx_done cycle. This guarantees at least
    // one IDLE cycle between back-to-back transfers.
    assign tx_ready = (state == S_IDLE) && !done_q;
    assign busy     = (state != S_IDLE);
    assign accept   = tx_valid && tx_ready;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_expire;
    logic            timeout_q;

    // The watchdog runs from INHIBIT exit (START entry) through WAIT_IDLE.
    // A transfer that completes on the expiry edge itself is not aborted.
    assign wd_expire = (state != S_IDLE) && (state != S_INHIBIT)
                       && (wd_cnt == WD_LAST)
                       && !((state == S_WAIT_IDLE) && bus_idle);
    assign tx_timeout = timeout_q;
`else
    assign tx_timeout = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Transmit FSM. The line-drive flops are updated on the same edge as the
    // state, so each *_oe output is a clean register output.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            shreg     <= 8'h00;
            parity_q  <= 1'b0;
            bit_idx   <= 3'd0;
            inh_cnt   <= '0;
            ack_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    if (accept) begin
                        shreg    <= tx_data;
                        parity_q <= ~^tx_data;
                        inh_cnt  <= '0;
                        clk_oe_q <= 1'b1;
                        state    <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        // Request-to-send: release the clock, drive the
                        // start bit (0).
                        clk_oe_q <= 1'b0;
                        dat_oe_q <= 1'b1;
                        state    <= S_START;
                    end else begin
                        inh_cnt <= inh_cnt + INH_W'(1);
                    end
                end

                S_START: begin
                    if (clk_fall) begin
                        dat_oe_q <= ~shreg[0];
                        bit_idx  <= 3'd0;
                        state    <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (clk_fall) begin
                        if (bit_idx == 3'd7) begin
                            dat_oe_q <= ~parity_q;
                            state    <= S_PARITY;
                        end else begin
                            dat_oe_q <= ~shreg[1];
                            shreg    <= {1'b0, shreg[7:1]};
                            bit_idx  <= bit_idx + 3'd1;
                        end
                    end
                end

                S_PARITY: begin
                    if (clk_fall) begin
                        dat_oe_q <= 1'b0;   // stop bit: line released
                        state    <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (clk_fall) begin
                        state <= S_ACK;
                    end
                end

                S_ACK: begin
                    if (clk_fall) begin
                        ack_q <= dat_s2;
                        state <= S_WAIT_IDLE;
                    end
                end

                S_WAIT_IDLE: begin
                    if (bus_idle) begin
                        done_q    <= 1'b1;
                        ack_err_q <= ack_q;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase

`ifdef PS2_TX_TIMEOUT_EN
            timeout_q <= 1'b0;
            if (state == S_INHIBIT) begin
                wd_cnt <= '0;
            end else if (state != S_IDLE) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            // Abort takes priority over any bit-clock progress this cycle.
            if (wd_expire) begin
                clk_oe_q  <= 1'b0;
                dat_oe_q  <= 1'b0;
                done_q    <= 1'b0;
                ack_err_q <= 1'b0;
                timeout_q <= 1'b1;
                state     <= S_IDLE;
            end
`endif
        end
    end

    assign tx_done    = done_q;
    assign tx_ack_err = ack_err_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign state_dbg  = state;

endmodule

// File: tb/tb_ps2_command_tx.sv
module tb_ps2_command_tx;

  localparam int INH = 10;
  localparam int TMO = 500;
  localparam int H   = 8;   // device half bit-clock period in system clocks

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, busy, tx_done, tx_ack_err, tx_timeout;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic [2:0] state_dbg;

  // Device side of the open-collector bus
  logic dev_clk, dev_dat;
  assign ps2_clk_in = ps2_clk_oe ? 1'b0 : dev_clk;
  assign ps2_dat_in = ps2_dat_oe ? 1'b0 : dev_dat;

  ps2_command_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_ack_err (tx_ack_err),
    .tx_timeout (tx_timeout),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .state_dbg  (state_dbg)
  );

  // Scoreboard: expected {parity, byte} per transfer, in send order
  logic [8:0] exp_q[$];
  int vec_cnt = 0;
  int err_cnt = 0;

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic do_reset();
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_dat  = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  // Returns at the negedge of the first INHIBIT cycle.
  task automatic start_send(input logic [7:0] b);
    @(negedge clock);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  // Called in the first INHIBIT cycle; returns in the first START cycle.
  task automatic run_inhibit(input string tag);
    int n = 0;
    bit dirty = 0;
    while (ps2_clk_oe === 1'b1 && n < 100) begin
      if (ps2_dat_oe !== 1'b0) dirty = 1;
      n++;
      @(negedge clock);
    end
    vec_cnt++;
    if (n != INH) begin
      err_cnt++;
      $display("FAIL %s inhibit_len: got %0d want %0d", tag, n, INH);
    end
    vec_cnt++;
    if (dirty) begin
      err_cnt++;
      $display("FAIL %s inhibit_dat_oe: dat_oe got 1 want 0 during inhibit", tag);
    end
    vec_cnt++;
    if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b1) begin
      err_cnt++;
      $display("FAIL %s start_lines: clk_oe=%b dat_oe=%b want 0/1", tag, ps2_clk_oe, ps2_dat_oe);
    end
  endtask

  // One device bit-clock period: falling edge, then rising edge.
  task automatic dev_edge();
    repeat (H) @(negedge clock);
    dev_clk = 1'b0;
    repeat (H) @(negedge clock);
    dev_clk = 1'b1;
  endtask

  // Device model: clocks a whole frame, captures the host's bits on the
  // rising edges, ACKs (or not), and checks the frame against the scoreboard.
  task automatic device_xfer(input bit do_ack, input string tag);
    logic [9:0] cap;
    logic [8:0] exp;
    logic       start_b;
    start_b = ps2_dat_in;
    cap = '0;
    for (int k = 1; k <= 12; k++) begin
      dev_edge();
      if (k <= 10) cap[k-1] = ps2_dat_in;
      if (k == 10 && do_ack) dev_dat = 1'b0;
    end
    dev_dat = 1'b1;
    vec_cnt++;
    if (start_b !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s start_bit: got %b want 0", tag, start_b);
    end
    vec_cnt++;
    if (exp_q.size() == 0) begin
      err_cnt++;
      $display("FAIL %s frame: got %h with no expected entry", tag, cap[8:0]);
    end else begin
      exp = exp_q.pop_front();
      if (cap[8:0] !== exp) begin
        err_cnt++;
        $display("FAIL %s frame {par,data}: got %h want %h", tag, cap[8:0], exp);
      end
    end
    vec_cnt++;
    if (cap[9] !== 1'b1) begin
      err_cnt++;
      $display("FAIL %s stop_bit: got %b want 1", tag, cap[9]);
    end
  endtask

  // Waits for tx_done, checks the pulse, and returns one cycle after it.
  task automatic wait_done(input logic exp_err, input string tag);
    int n = 0;
    while (tx_done !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    vec_cnt++;
    if (tx_done !== 1'b1) begin
      err_cnt++;
      $display("FAIL %s done_timeout: tx_done got %b want 1 within 100 cycles", tag, tx_done);
    end else begin
      vec_cnt++;
      if (tx_ack_err !== exp_err) begin
        err_cnt++;
        $display("FAIL %s ack_err: got %b want %b", tag, tx_ack_err, exp_err);
      end
      vec_cnt++;
      if (tx_ready !== 1'b0 || busy !== 1'b0) begin
        err_cnt++;
        $display("FAIL %s done_cycle: ready=%b busy=%b want 0/0", tag, tx_ready, busy);
      end
      @(negedge clock);
      vec_cnt++;
      if (tx_done !== 1'b0 || tx_ack_err !== 1'b0) begin
        err_cnt++;
        $display("FAIL %s pulse_width: done=%b ack_err=%b want 0/0", tag, tx_done, tx_ack_err);
      end
      vec_cnt++;
      if (tx_ready !== 1'b1 || busy !== 1'b0) begin
        err_cnt++;
        $display("FAIL %s ready_after_done: ready=%b busy=%b want 1/0", tag, tx_ready, busy);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Tests
  // -------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    vec_cnt++;
    if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_lines: clk_oe=%b dat_oe=%b want 0/0", ps2_clk_oe, ps2_dat_oe);
    end
    vec_cnt++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_status: ready=%b busy=%b want 1/0", tx_ready, busy);
    end
    vec_cnt++;
    if (tx_done !== 1'b0 || tx_ack_err !== 1'b0 || tx_timeout !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_pulses: done=%b ack_err=%b timeout=%b want 0/0/0", tx_done, tx_ack_err, tx_timeout);
    end
    vec_cnt++;
    if (state_dbg !== 3'd0) begin
      err_cnt++;
      $display("FAIL reset_state: got %0d want 0", state_dbg);
    end
  endtask

  // 0xED = 1110_1101: LSB first 1,0,1,1,0,1,1,1; six ones -> parity 1
  task automatic test_send_ed();
    exp_q.push_back(9'h1ED);
    start_send(8'hED);
    vec_cnt++;
    if (busy !== 1'b1 || tx_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL ed_busy: busy=%b ready=%b want 1/0", busy, tx_ready);
    end
    run_inhibit("ed");
    device_xfer(1'b1, "ed");
    wait_done(1'b0, "ed");
  endtask

  // 0xF4 = 1111_0100: five ones -> parity 0; device does not ACK
  task automatic test_ack_err();
    exp_q.push_back(9'h0F4);
    start_send(8'hF4);
    run_inhibit("f4");
    device_xfer(1'b0, "f4");
    wait_done(1'b1, "f4");
  endtask

  // 0xFF then 0x55 held on tx_valid: 0x55 may only go out after tx_ready
  task automatic test_back_to_back();
    exp_q.push_back(9'h1FF);
    exp_q.push_back(9'h155);
    @(negedge clock);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    @(negedge clock);
    tx_data  = 8'h55;
    vec_cnt++;
    if (tx_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL b2b_ready_busy: got %b want 0", tx_ready);
    end
    run_inhibit("b2b_ff");
    device_xfer(1'b1, "b2b_ff");
    wait_done(1'b0, "b2b_ff");
    @(negedge clock);
    tx_valid = 1'b0;
    vec_cnt++;
    if (busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL b2b_second_accept: busy got %b want 1", busy);
    end
    run_inhibit("b2b_55");
    device_xfer(1'b1, "b2b_55");
    wait_done(1'b0, "b2b_55");
  endtask

  // 0xA5 = 1010_0101: bit3 is 0, so the host drives data low after edge 4
  task automatic test_reset_mid();
    bit done_seen = 0;
    start_send(8'hA5);
    run_inhibit("rst_mid");
    for (int k = 0; k < 4; k++) dev_edge();
    repeat (2) @(negedge clock);
    vec_cnt++;
    if (ps2_dat_oe !== 1'b1) begin
      err_cnt++;
      $display("FAIL rst_mid_bit3: dat_oe got %b want 1", ps2_dat_oe);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    vec_cnt++;
    if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
      err_cnt++;
      $display("FAIL rst_mid_lines: clk_oe=%b dat_oe=%b want 0/0", ps2_clk_oe, ps2_dat_oe);
    end
    vec_cnt++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL rst_mid_status: ready=%b busy=%b want 1/0", tx_ready, busy);
    end
    for (int i = 0; i < 50; i++) begin
      if (tx_done === 1'b1) done_seen = 1;
      @(negedge clock);
    end
    vec_cnt++;
    if (done_seen) begin
      err_cnt++;
      $display("FAIL rst_mid_no_done: tx_done got 1 want 0");
    end
  endtask

  // Device never clocks after the request-to-send
  task automatic test_stall();
    int n = 0;
    bit saw_timeout = 0;
    bit saw_done = 0;
    start_send(8'h12);
    run_inhibit("stall");
`ifdef PS2_TX_TIMEOUT_EN
    while (tx_timeout !== 1'b1 && n < 2 * TMO) begin
      if (tx_done === 1'b1) saw_done = 1;
      @(negedge clock);
      n++;
    end
    vec_cnt++;
    if (n != TMO) begin
      err_cnt++;
      $display("FAIL stall_timeout_cycle: got %0d want %0d", n, TMO);
    end
    vec_cnt++;
    if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || busy !== 1'b0 || tx_done !== 1'b0 || saw_done) begin
      err_cnt++;
      $display("FAIL stall_abort: clk_oe=%b dat_oe=%b busy=%b done=%b want 0/0/0/0", ps2_clk_oe, ps2_dat_oe, busy, tx_done);
    end
    @(negedge clock);
    vec_cnt++;
    if (tx_timeout !== 1'b0 || tx_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL stall_after: timeout=%b ready=%b want 0/1", tx_timeout, tx_ready);
    end
`else
    for (int i = 0; i < 2 * TMO; i++) begin
      if (tx_timeout === 1'b1) saw_timeout = 1;
      if (tx_done === 1'b1) saw_done = 1;
      @(negedge clock);
      n++;
    end
    vec_cnt++;
    if (busy !== 1'b1 || ps2_dat_oe !== 1'b1) begin
      err_cnt++;
      $display("FAIL stall_busy: busy=%b dat_oe=%b want 1/1", busy, ps2_dat_oe);
    end
    vec_cnt++;
    if (saw_timeout || saw_done) begin
      err_cnt++;
      $display("FAIL stall_no_pulse: timeout=%b done=%b want 0/0", saw_timeout, saw_done);
    end
    do_reset();
`endif
  endtask

  // -------------------------------------------------------------------------
  // Sequence and final report
  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_send_ed();
    test_ack_err();
    test_back_to_back();
    test_reset_mid();
    test_stall();
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
